// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, widths and line-level constants.
// The receiver imports this same package so both ends agree on framing.
package uart_pkg;

  localparam int DATA_WIDTH     = 8;
  localparam int PRESCALE_WIDTH = 6;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Last edge-counter value of a bit; a prescale of 0 behaves like 1.
  function automatic logic [PRESCALE_WIDTH-1:0] bit_last(
    input logic [PRESCALE_WIDTH-1:0] p
  );
    return (p == '0) ? '0 : p - PRESCALE_WIDTH'(1);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Parallel-side request bundle and serial-side status of the UART transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_WIDTH-1:0]     P_DATA;
  logic                      DATA_VALID;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      TX_OUT;
  logic                      busy;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, prescale,
    input  TX_OUT, busy
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, prescale,
    output TX_OUT, busy
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// Data shift register and parity bit for one frame. Parity is computed once
// at load time so it stays valid after the data has been shifted out.
module tx_serializer
  import uart_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  par_typ,
  output logic                  bit_cur,
  output logic                  bit_nxt,
  output logic                  par_bit
);

  logic [DATA_WIDTH-1:0] sh_reg;
  logic                  par_reg;

  // Latch byte and parity on accept, shift right (LSB first) per data bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_reg  <= '0;
      par_reg <= 1'b0;
    end else if (load) begin
      sh_reg  <= din;
      par_reg <= (^din) ^ par_typ;
    end else if (shift) begin
      sh_reg  <= {1'b0, sh_reg[DATA_WIDTH-1:1]};
    end
  end

  assign bit_cur = sh_reg[0];
  assign bit_nxt = sh_reg[1];
  assign par_bit = par_reg;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: frame FSM, edge/bit counters and registered line outputs.
// TX_OUT and busy are registered from the next state so the start bit
// appears the cycle right after accept.
module uart_tx
  import uart_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave tx_if
);

  uart_state_e               state, next_state;
  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [2:0]                bit_cnt;
  logic [PRESCALE_WIDTH-1:0] p_reg;
  logic                      par_en_reg;
  logic                      tx_out_reg, busy_reg;
  logic                      tx_d, busy_d;
  logic                      accept, bit_done, last_bit, shift;
  logic                      bit_cur, bit_nxt, par_bit;

  assign accept   = (state == IDLE) && tx_if.DATA_VALID;
  assign bit_done = (edge_cnt == bit_last(p_reg));
  assign last_bit = (bit_cnt == 3'(DATA_WIDTH - 1));
  assign shift    = (state == DATA) && bit_done;

  tx_serializer u_ser (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .shift   (shift),
    .din     (tx_if.P_DATA),
    .par_typ (tx_if.PAR_TYP),
    .bit_cur (bit_cur),
    .bit_nxt (bit_nxt),
    .par_bit (par_bit)
  );

  // State register; reset wins over a same-cycle accept.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: every non-idle bit lasts until the edge counter wraps.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept)   next_state = START;
      START:   if (bit_done) next_state = DATA;
      DATA:    if (bit_done && last_bit) next_state = par_en_reg ? PARITY : STOP;
      PARITY:  if (bit_done) next_state = STOP;
      STOP:    if (bit_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic: line level for the coming cycle, looked up from next state.
  always_comb begin
    tx_d   = STOP_BIT;
    busy_d = (next_state != IDLE);
    case (next_state)
      START:   tx_d = START_BIT;
      DATA:    tx_d = shift ? bit_nxt : bit_cur;
      PARITY:  tx_d = par_bit;
      default: tx_d = STOP_BIT;
    endcase
  end

  // Registered line outputs; idle high, not busy, out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_out_reg <= STOP_BIT;
      busy_reg   <= 1'b0;
    end else begin
      tx_out_reg <= tx_d;
      busy_reg   <= busy_d;
    end
  end

  // Frame configuration, captured only on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_reg      <= '0;
      par_en_reg <= 1'b0;
    end else if (accept) begin
      p_reg      <= tx_if.prescale;
      par_en_reg <= tx_if.PAR_EN;
    end
  end

  // Edge counter: 0..P-1 inside each bit, held at 0 while idle.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE || bit_done) edge_cnt <= '0;
    else                                  edge_cnt <= edge_cnt + PRESCALE_WIDTH'(1);
  end

  // Bit counter: indexes data bits 0..7, wraps naturally after bit 7.
  always_ff @(posedge clk) begin
    if (rst || state != DATA) bit_cnt <= '0;
    else if (bit_done)        bit_cnt <= bit_cnt + 3'd1;
  end

  assign tx_if.TX_OUT = tx_out_reg;
  assign tx_if.busy   = busy_reg;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have a single clock; reset SHALL be synchronous and active-high; polarity and synchronicity are fixed.
REQ-002 clk  input  1  rising-edge clock; sole clock of the block.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 P_DATA  input  8  parallel byte to transmit; sampled only on accept.
REQ-005 DATA_VALID  input  1  request to send P_DATA; level-qualified, no pulse requirement.
REQ-006 PAR_EN  input  1  1 = parity bit inserted after data; sampled on accept.
REQ-007 PAR_TYP  input  1  0 = even, 1 = odd parity; sampled on accept.
REQ-008 prescale  input  6  clk cycles per serial bit, matching the receiver oversample ratio; sampled on accept.
REQ-009 TX_OUT  output  1  serial line, idle high, registered.
REQ-010 busy  output  1  1 while a frame is in progress, registered.

Function
REQ-011 Frame SHALL be: start (0), 8 data bits LSB first, optional parity, stop (1); 10 bits without parity, 11 with.
REQ-012 Accept SHALL occur in any cycle with state IDLE and DATA_VALID=1; DATA_VALID while busy=1 SHALL be ignored, with no queuing.
REQ-013 On accept, P_DATA, PAR_EN, PAR_TYP and prescale SHALL be latched; input changes during the frame SHALL have no effect.
REQ-014 Latency: with accept in cycle N, TX_OUT=0 and busy=1 SHALL first appear in cycle N+1.
REQ-015 Each bit SHALL be held for exactly P cycles, where P = latched prescale; prescale=0 SHALL be treated as P=1.
REQ-016 States SHALL be: IDLE, START, DATA, PARITY, STOP.
- IDLE->START on accept.
- START->DATA after P cycles.
- DATA->PARITY when PAR_EN=1, else DATA->STOP, after bit 7 completes.
- PARITY->STOP after P cycles.
- STOP->IDLE after P cycles.
REQ-017 A 6-bit edge counter SHALL count 0..P-1 within each bit and wrap to 0 on bit boundaries; a 3-bit bit counter SHALL index data bits 0..7.
REQ-018 Parity bit SHALL be XOR of the 8 latched data bits for even parity, and its inverse for odd parity.
REQ-019 busy SHALL fall in the cycle after the last stop-bit cycle, i.e. when state returns to IDLE.
- DATA_VALID=1 in that IDLE cycle SHALL be accepted.
- Back-to-back frames are therefore separated by exactly one idle-high clk cycle.
REQ-020 Outside START, DATA and PARITY, TX_OUT SHALL be 1.

Reset
REQ-021 rst=1 SHALL take effect at the next clk edge, force state IDLE, TX_OUT=1, busy=0, and clear both counters and the data/config registers.
REQ-022 Reset mid-frame SHALL abort the frame with no stop bit; TX_OUT=1 from the cycle after the reset edge.
REQ-023 A DATA_VALID asserted during the reset cycle SHALL NOT be accepted.
REQ-024 Reset SHALL have priority over accept.

Structure
REQ-025 Shared package uart_pkg SHALL hold:
- the state enumeration;
- DATA_WIDTH=8 and PRESCALE_WIDTH=6;
- START_BIT=0 and STOP_BIT=1 constants.
The receiver SHALL reuse the same package.
REQ-026 One sub-module, tx_serializer, SHALL hold the shift register and parity computation; FSM and counters SHALL reside in uart_tx.

Verification
REQ-027 Test 1: P_DATA=0xA5, PAR_EN=0, prescale=8 -> TX_OUT = 0,1,0,1,0,0,1,0,1,1, each held 8 cycles; busy high for exactly 80 cycles.
REQ-028 Test 2: P_DATA=0xA5, PAR_EN=1, prescale=16.
- PAR_TYP=0 -> parity bit 0.
- PAR_TYP=1 -> parity bit 1.
- busy high for 176 cycles in both cases.
REQ-029 Test 3: DATA_VALID held high with 0x3C then 0xC3, prescale=8, PAR_EN=0 -> both frames transmitted, separated by exactly 1 idle-high cycle; P_DATA change mid-frame not reflected.
REQ-030 Test 4: rst=1 in cycle 30 of a prescale=8 frame -> TX_OUT=1 and busy=0 from cycle 31; next accepted byte transmitted correctly.
REQ-031 Test 5: prescale changed from 8 to 32 mid-frame -> current frame keeps 8-cycle bits; next frame uses 32-cycle bits.
REQ-032 Test 6: loopback into the UART_RX receiver with matching PAR_EN, PAR_TYP and prescale, 256 random bytes -> every byte received with par_err=0 and stp_err=0.
